// File: rtl/uart_pkg.sv
// Shared UART definitions used by rs232in, rs232out and uart_rx_fifo.
package uart_pkg;

    typedef logic [7:0] byte_t;

    localparam int unsigned UART_BAUD   = 115200;
    localparam int unsigned UART_CLK_HZ = 48000000;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Byte-stream and status bundle of uart_rx_fifo.
// Carries ovf_count only when UART_RX_FIFO_OVF_COUNT_EN is defined.
interface uart_rx_fifo_if #(
    parameter int unsigned DEPTH_LOG2 = 4
);
    import uart_pkg::*;

    logic                in_valid;
    byte_t               in_data;
    logic                out_valid;
    logic                out_ready;
    byte_t               out_data;
    logic [DEPTH_LOG2:0] level;
    logic                high_water;
    logic                overflow;
    logic                overflow_clr;
`ifdef UART_RX_FIFO_OVF_COUNT_EN
    logic [7:0]          ovf_count;
`endif

    // Producer/consumer side (rs232in plus the byte consumer).
    modport master (
        output in_valid, in_data, out_ready, overflow_clr,
`ifdef UART_RX_FIFO_OVF_COUNT_EN
        input  ovf_count,
`endif
        input  out_valid, out_data, level, high_water, overflow
    );

    // FIFO side.
    modport slave (
        input  in_valid, in_data, out_ready, overflow_clr,
`ifdef UART_RX_FIFO_OVF_COUNT_EN
        output ovf_count,
`endif
        output out_valid, out_data, level, high_water, overflow
    );

endinterface

// File: rtl/uart_fifo_mem.sv
// 2**DEPTH_LOG2 x 8 storage: synchronous write, asynchronous read
// (maps onto ECP5 distributed RAM).
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [DEPTH_LOG2-1:0] waddr_i,
    input  byte_t                 wdata_i,
    input  logic [DEPTH_LOG2-1:0] raddr_i,
    output byte_t                 rdata_o
);

    byte_t mem_q [2**DEPTH_LOG2];

    // Write port; contents are deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO between rs232in and a valid/ready consumer.
// Show-ahead output, registered level/high-water/sticky overflow flags.
// Define UART_RX_FIFO_OVF_COUNT_EN to add the saturating ovf_count counter.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned HIGH_WATER = 12
) (
    input  logic         clk48,
    input  logic         rst_n,
    uart_rx_fifo_if.slave bus
);

    localparam logic [DEPTH_LOG2:0] HwLevel = HIGH_WATER[DEPTH_LOG2:0];
    localparam logic [DEPTH_LOG2:0] PtrOne  = {{DEPTH_LOG2{1'b0}}, 1'b1};

    logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0] level_q, level_d;
    logic                high_water_q, high_water_d;
    logic                overflow_q, overflow_d;
    logic                full, push, pop, drop;
    byte_t               rdata;

    // Full when low bits match and the wrap bits differ.
    assign full = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                  (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
    assign pop  = (level_q != '0) && bus.out_ready;
    // A full FIFO being popped this cycle can still take the incoming byte.
    assign push = bus.in_valid && (!full || pop);
    assign drop = bus.in_valid && full && !pop;

    // Next-state for pointers, level and flags.
    always_comb begin
        wr_ptr_d     = push ? wr_ptr_q + PtrOne : wr_ptr_q;
        rd_ptr_d     = pop ? rd_ptr_q + PtrOne : rd_ptr_q;
        level_d      = wr_ptr_d - rd_ptr_d;
        high_water_d = (level_d >= HwLevel);
        // Set wins over clear.
        overflow_d   = drop || (overflow_q && !bus.overflow_clr);
    end

    // Pointer, level and flag registers.
    always_ff @(posedge clk48 or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            high_water_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            high_water_q <= high_water_d;
            overflow_q   <= overflow_d;
        end
    end

`ifdef UART_RX_FIFO_OVF_COUNT_EN
    logic [7:0] ovf_count_q, ovf_count_d;

    // Saturating drop counter; a drop coinciding with clear restarts at 1.
    always_comb begin
        ovf_count_d = ovf_count_q;
        if (drop) begin
            if (bus.overflow_clr) begin
                ovf_count_d = 8'd1;
            end else if (ovf_count_q != 8'hff) begin
                ovf_count_d = ovf_count_q + 8'd1;
            end
        end else if (bus.overflow_clr) begin
            ovf_count_d = 8'd0;
        end
    end

    // Drop counter register.
    always_ff @(posedge clk48 or negedge rst_n) begin
        if (!rst_n) begin
            ovf_count_q <= 8'd0;
        end else begin
            ovf_count_q <= ovf_count_d;
        end
    end

    assign bus.ovf_count = ovf_count_q;
`endif

    uart_fifo_mem #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_mem (
        .clk_i   (clk48),
        .we_i    (push),
        .waddr_i (wr_ptr_q[DEPTH_LOG2-1:0]),
        .wdata_i (bus.in_data),
        .raddr_i (rd_ptr_q[DEPTH_LOG2-1:0]),
        .rdata_o (rdata)
    );

    assign bus.out_valid  = (level_q != '0);
    assign bus.out_data   = rdata;
    assign bus.level      = level_q;
    assign bus.high_water = high_water_q;
    assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: the driver pushes accepted bytes into a
// reference queue, a negedge monitor pops and compares on every handshake.
module tb_uart_rx_fifo;
    import uart_pkg::*;

    localparam int Depth = 16;
    localparam int Hw    = 12;

    logic clk48 = 1'b0;
    logic rst_n = 1'b0;

    uart_rx_fifo_if #(.DEPTH_LOG2(4)) bus ();

    uart_rx_fifo #(
        .DEPTH_LOG2(4),
        .HIGH_WATER(Hw)
    ) dut (
        .clk48 (clk48),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #10 clk48 = ~clk48;

    // Reference model state.
    byte_t exp_q[$];
    bit    m_ovf = 1'b0;
    int    m_cnt = 0;
    int    n_push = 0;
    byte_t last_pop = 8'h00;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One cycle of stimulus, called just after a rising edge.
    task automatic drive(input bit iv, input byte_t d, input bit rdy, input bit clr);
        int sz;
        bit pop_m, push_m, drop_m;
        bus.in_valid     = iv;
        bus.in_data      = d;
        bus.out_ready    = rdy;
        bus.overflow_clr = clr;
        sz     = exp_q.size();
        pop_m  = rdy && (sz != 0);
        push_m = iv && ((sz < Depth) || pop_m);
        drop_m = iv && (sz == Depth) && !pop_m;
        @(posedge clk48);
        #1;
        if (push_m) begin
            exp_q.push_back(d);
            n_push++;
        end
        if (drop_m) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        if (drop_m) m_cnt = clr ? 1 : ((m_cnt == 255) ? 255 : m_cnt + 1);
        else if (clr) m_cnt = 0;
    endtask

    // Monitor: status checks every cycle, data checks on each handshake.
    always @(negedge clk48) begin
        if (rst_n) begin
            chk("out_valid", int'(bus.out_valid), int'(exp_q.size() != 0));
            chk("level", int'(bus.level), exp_q.size());
            chk("high_water", int'(bus.high_water), int'(exp_q.size() >= Hw));
            chk("overflow", int'(bus.overflow), int'(m_ovf));
`ifdef UART_RX_FIFO_OVF_COUNT_EN
            chk("ovf_count", int'(bus.ovf_count), m_cnt);
`endif
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pop", 1, 0);
                end else begin
                    chk("out_data", int'(bus.out_data), int'(exp_q[0]));
                    last_pop = exp_q.pop_front();
                end
            end
        end
    end

    byte_t hello [14] = '{8'h48, 8'h65, 8'h6c, 8'h6c, 8'h6f, 8'h20, 8'h57,
                          8'h6f, 8'h72, 8'h6c, 8'h64, 8'h21, 8'h0d, 8'h0a};

    initial begin
        bus.in_valid     = 1'b0;
        bus.in_data      = 8'h00;
        bus.out_ready    = 1'b0;
        bus.overflow_clr = 1'b0;
        #1;
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_level", int'(bus.level), 0);
        chk("rst_high_water", int'(bus.high_water), 0);
        chk("rst_overflow", int'(bus.overflow), 0);
        @(posedge clk48);
        #1;
        rst_n = 1'b1;

        // Single byte in and out.
        drive(1'b1, 8'h48, 1'b0, 1'b0);
        chk("single_data", int'(bus.out_data), 8'h48);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);

        // Burst with consumer stalled, then drain.
        foreach (hello[i]) drive(1'b1, hello[i], 1'b0, 1'b0);
        chk("hello_level", int'(bus.level), 14);
        for (int i = 0; i < 16; i++) drive(1'b0, 8'h00, 1'b1, 1'b0);
        chk("hello_last", int'(last_pop), 8'h0a);

        // Fill, overflow, overflow coinciding with clear, then clear.
        for (int i = 0; i < Depth; i++) drive(1'b1, byte_t'(i), 1'b0, 1'b0);
        drive(1'b1, 8'h55, 1'b0, 1'b0);
        drive(1'b1, 8'h66, 1'b0, 1'b1);
        chk("ovf_set_wins", int'(bus.overflow), 1);
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        // Push while popping a full FIFO.
        drive(1'b1, 8'haa, 1'b1, 1'b0);
        chk("full_pushpop_level", int'(bus.level), Depth);
        for (int i = 0; i < 20; i++) drive(1'b0, 8'h00, 1'b1, 1'b0);
        chk("aa_last", int'(last_pop), 8'haa);

        // Random traffic.
        n_push = 0;
        for (int i = 0; i < 16000; i++) begin
            drive($urandom_range(3) == 0, byte_t'($urandom), $urandom_range(1) == 1,
                  $urandom_range(63) == 0);
        end
        chk("ptr_wraps_ge_100", int'((n_push / 32) >= 100), 1);
        for (int i = 0; i < 20; i++) drive(1'b0, 8'h00, 1'b1, 1'b1);

        // Asynchronous reset with data in flight.
        for (int i = 0; i < 7; i++) drive(1'b1, byte_t'(8'h30 + i), 1'b0, 1'b0);
        chk("pre_rst_level", int'(bus.level), 7);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", int'(bus.out_valid), 0);
        chk("mid_rst_level", int'(bus.level), 0);
        chk("mid_rst_high_water", int'(bus.high_water), 0);
        chk("mid_rst_overflow", int'(bus.overflow), 0);
`ifdef UART_RX_FIFO_OVF_COUNT_EN
        chk("mid_rst_ovf_count", int'(bus.ovf_count), 0);
`endif
        exp_q.delete();
        m_ovf = 1'b0;
        m_cnt = 0;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk48);
        #1;
        rst_n = 1'b1;
        drive(1'b1, 8'h21, 1'b0, 1'b0);
        chk("post_rst_data", int'(bus.out_data), 8'h21);
        chk("post_rst_level", int'(bus.level), 1);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
